// File: rtl/pixel_array_pkg.sv
// Shared types and constants for the pixel array readout block.
// Holds the controller state encoding and a width helper safe for tiny arrays.
package pixel_array_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_READ
  } state_e;

  localparam int DEF_WIDTH         = 3;
  localparam int DEF_HEIGHT        = 3;
  localparam int DEF_BITS          = 8;
  localparam int DEF_ERASE_CYCLES  = 4;
  localparam int DEF_EXPOSE_CYCLES = 16;

  // A 1-wide dimension still needs a 1-bit index signal.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pixel_array_readout_cell.sv
// One digital pixel: latches the shared ramp code the first time it equals
// the pixel's trip level during conversion; erase clears code and trip flag.
module pixel_cell
  import pixel_array_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            convert,
  input  logic [BITS-1:0] counter,
  input  logic [BITS-1:0] level,
  output logic [BITS-1:0] code
);

  logic [BITS-1:0] code_q;
  logic            trip_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_q <= '0;
      trip_q <= 1'b0;
    end else if (clear) begin
      code_q <= '0;
      trip_q <= 1'b0;
    end else if (convert && !trip_q && (counter == level)) begin
      code_q <= counter;
      trip_q <= 1'b1;
    end
  end

  assign code = code_q;

endmodule

// File: rtl/pixel_array_readout.sv
// Frame controller for a WIDTH x HEIGHT digital pixel array: erase, expose,
// single-slope ramp conversion, then raster readout over a valid/ready port.
module pixel_array_readout
  import pixel_array_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int HEIGHT        = DEF_HEIGHT,
  parameter int BITS          = DEF_BITS,
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [WIDTH*HEIGHT*BITS-1:0]    pixel_level,
  input  logic                            out_ready,
  output logic                            erase,
  output logic                            expose,
  output logic                            convert,
  output logic [BITS-1:0]                 counter,
  output logic [HEIGHT-1:0]               row_sel,
  output logic                            out_valid,
  output logic [BITS-1:0]                 out_data,
  output logic [clog2_min1(HEIGHT)-1:0]   out_row,
  output logic [clog2_min1(WIDTH)-1:0]    out_col,
  output logic                            out_last,
  output logic                            busy,
  output logic                            frame_done
);

  localparam int N    = WIDTH * HEIGHT;
  localparam int RW   = clog2_min1(HEIGHT);
  localparam int CW   = clog2_min1(WIDTH);
  localparam int IW   = clog2_min1(N);
  localparam int PMAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int PW   = clog2_min1(PMAX);
  localparam logic [BITS-1:0] CMAX = {BITS{1'b1}};

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q;
  logic [BITS-1:0] counter_q;
  logic [RW-1:0]   row_q;
  logic [CW-1:0]   col_q;
  logic            erase_q, expose_q, convert_q, valid_q, busy_q, frame_done_q;
  logic            last_pix;
  logic [IW-1:0]   rd_idx;
  logic [BITS-1:0] codes [N];

  assign last_pix = (row_q == RW'(HEIGHT - 1)) && (col_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_ERASE;
      ST_ERASE:   if (phase_q == PW'(ERASE_CYCLES - 1)) state_d = ST_EXPOSE;
      ST_EXPOSE:  if (phase_q == PW'(EXPOSE_CYCLES - 1)) state_d = ST_CONVERT;
      ST_CONVERT: if (counter_q == CMAX) state_d = ST_READ;
      ST_READ:    if (out_ready && last_pix) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Phase outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      counter_q    <= '0;
      row_q        <= '0;
      col_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= ((state_d == state_q) && ((state_q == ST_ERASE) || (state_q == ST_EXPOSE)))
                      ? phase_q + 1'b1 : '0;
      counter_q    <= ((state_q == ST_CONVERT) && (state_d == ST_CONVERT)) ? counter_q + 1'b1 : '0;
      erase_q      <= (state_d == ST_ERASE);
      expose_q     <= (state_d == ST_EXPOSE);
      convert_q    <= (state_d == ST_CONVERT);
      valid_q      <= (state_d == ST_READ);
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_q == ST_READ) && (state_d == ST_IDLE);
      if (state_q != ST_READ) begin
        row_q <= '0;
        col_q <= '0;
      end else if (out_ready && !last_pix) begin
        if (col_q == CW'(WIDTH - 1)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_cell
    pixel_cell #(.BITS(BITS)) u_cell (
      .clk     (clk),
      .reset   (reset),
      .clear   (erase_q),
      .convert (convert_q),
      .counter (counter_q),
      .level   (pixel_level[gi*BITS +: BITS]),
      .code    (codes[gi])
    );
  end

  for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row_sel
    assign row_sel[gi] = valid_q && (row_q == RW'(gi));
  end

  assign rd_idx     = IW'(int'(row_q) * WIDTH + int'(col_q));
  assign out_data   = valid_q ? codes[rd_idx] : '0;
  assign out_row    = valid_q ? row_q : '0;
  assign out_col    = valid_q ? col_q : '0;
  assign out_last   = valid_q && last_pix;
  assign out_valid  = valid_q;
  assign erase      = erase_q;
  assign expose     = expose_q;
  assign convert    = convert_q;
  assign counter    = counter_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_array_readout.sv
// Randomised frame-level bench: each frame's expected pixel codes are the
// levels applied during conversion, streamed in raster order.
module tb_pixel_array_readout;
  import pixel_array_pkg::*;

  localparam int W    = 3;
  localparam int H    = 2;
  localparam int B    = 4;
  localparam int EC   = 2;
  localparam int XC   = 4;
  localparam int N    = W * H;
  localparam int RW   = clog2_min1(H);
  localparam int CW   = clog2_min1(W);
  localparam int RAMP = 1 << B;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [N*B-1:0] pixel_level = '0;
  logic           out_ready = 1'b1;
  logic           erase, expose, convert, out_valid, out_last, busy, frame_done;
  logic [B-1:0]   counter, out_data;
  logic [H-1:0]   row_sel;
  logic [RW-1:0]  out_row;
  logic [CW-1:0]  out_col;

  pixel_array_readout #(
    .WIDTH(W), .HEIGHT(H), .BITS(B), .ERASE_CYCLES(EC), .EXPOSE_CYCLES(XC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pixel_level(pixel_level),
    .out_ready(out_ready), .erase(erase), .expose(expose), .convert(convert),
    .counter(counter), .row_sel(row_sel), .out_valid(out_valid),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: counts phase lengths, checks the ramp and stall stability, logs handshakes.
  int erase_cnt = 0, expose_cnt = 0, conv_cnt = 0, done_cnt = 0, done_cyc = 0, conv_run = 0;
  bit prev_stall = 1'b0;
  logic [B-1:0]  prev_data;
  logic [RW-1:0] prev_row;
  logic [CW-1:0] prev_col;
  int hs_data[$], hs_row[$], hs_col[$], hs_last[$];

  always @(negedge clk) begin
    if (reset) begin
      if (erase)  erase_cnt++;
      if (expose) expose_cnt++;
      if (convert) begin
        conv_cnt++;
        chk("ramp", 32'(counter), conv_run);
        conv_run++;
      end else begin
        conv_run = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
        chk("stall_pos", {30'd0, out_row, out_col}, {30'd0, prev_row, prev_col});
      end
      chk("row_sel", 32'(row_sel), out_valid ? (32'd1 << out_row) : 32'd0);
      if (out_valid && out_ready) begin
        hs_data.push_back(int'(out_data));
        hs_row.push_back(int'(out_row));
        hs_col.push_back(int'(out_col));
        hs_last.push_back(int'(out_last));
        $display("pixel r=%0d c=%0d data=%0d last=%0d", out_row, out_col, out_data, out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_row   = out_row;
      prev_col   = out_col;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_valid", 32'(out_valid), 0);
        chk("done_busy", 32'(busy), 0);
      end
    end else begin
      conv_run   = 0;
      prev_stall = 1'b0;
    end
  end

  int exp_lv[N];

  task automatic set_levels();
    for (int i = 0; i < N; i++) pixel_level[i*B +: B] = exp_lv[i][B-1:0];
  endtask

  task automatic randomize_levels();
    for (int i = 0; i < N; i++) exp_lv[i] = int'($urandom_range(0, RAMP - 1));
  endtask

  // mode 0: ready held high, 1: repeating 1,0,0,1 ready pattern, 2: random ready
  task automatic run_frame(input int mode, input bit spam, input string name);
    int e0, x0, c0, d0, h0, scyc, k;
    bit spam_x, spam_r, timeout;
    bit [3:0] pat;
    pat = 4'b1001;
    k = 0; spam_x = 1'b0; spam_r = 1'b0; timeout = 1'b1;
    @(posedge clk); #1;
    e0 = erase_cnt; x0 = expose_cnt; c0 = conv_cnt; d0 = done_cnt; h0 = hs_data.size();
    set_levels();
    start = 1'b1;
    out_ready = 1'b1;
    scyc = cyc;
    for (int t = 0; t < 2000; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done_cnt > d0) begin
        timeout = 1'b0;
        break;
      end
      if (spam && expose && !spam_x) begin start = 1'b1; spam_x = 1'b1; end
      if (spam && out_valid && !spam_r) begin start = 1'b1; spam_r = 1'b1; end
      if (out_valid) begin
        case (mode)
          1:       out_ready = pat[k % 4];
          2:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = 1'b1;
        endcase
        k++;
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    chk({name, "_timeout"}, 32'(timeout), 0);
    chk({name, "_erase_len"}, erase_cnt - e0, EC);
    chk({name, "_expose_len"}, expose_cnt - x0, XC);
    chk({name, "_convert_len"}, conv_cnt - c0, RAMP);
    chk({name, "_done_once"}, done_cnt - d0, 1);
    if (mode == 0) chk({name, "_latency"}, done_cyc - scyc, 1 + EC + XC + RAMP + N);
    chk({name, "_pix_count"}, hs_data.size() - h0, N);
    for (int i = 0; i < N; i++) begin
      if (h0 + i < hs_data.size()) begin
        chk({name, "_data"}, hs_data[h0+i], exp_lv[i]);
        chk({name, "_row"}, hs_row[h0+i], i / W);
        chk({name, "_col"}, hs_col[h0+i], i % W);
        chk({name, "_last"}, hs_last[h0+i], (i == N - 1) ? 1 : 0);
      end
    end
    if (spam) begin
      repeat (3) @(posedge clk);
      #1;
      chk({name, "_no_requeue"}, 32'(busy), 0);
    end
    $display("frame %s complete, %0d pixels seen", name, hs_data.size() - h0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_phase"}, {29'd0, erase, expose, convert}, 0);
    chk({name, "_counter"}, 32'(counter), 0);
    chk({name, "_row_sel"}, 32'(row_sel), 0);
    chk({name, "_valid"}, 32'(out_valid), 0);
    chk({name, "_data"}, 32'(out_data), 0);
    chk({name, "_pos"}, {30'd0, out_row, out_col}, 0);
    chk({name, "_last_done"}, {30'd0, out_last, frame_done}, 0);
  endtask

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < N; i++) exp_lv[i] = i;
    run_frame(0, 1'b0, "raster");

    randomize_levels();
    exp_lv[0] = 0;
    exp_lv[N-1] = RAMP - 1;
    run_frame(1, 1'b0, "corners_stall");

    randomize_levels();
    run_frame(0, 1'b1, "start_spam");

    // Abort a frame mid-conversion; the next frame must carry only fresh codes.
    randomize_levels();
    set_levels();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (convert && counter == 7) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_count7", 32'(found), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    randomize_levels();
    run_frame(2, 1'b0, "after_reset");

    randomize_levels();
    run_frame(0, 1'b0, "b2b_first");
    for (int i = 0; i < N; i++) exp_lv[i] = (exp_lv[i] + 1 + i) % RAMP;
    run_frame(0, 1'b0, "b2b_second");

    randomize_levels();
    run_frame(2, 1'b0, "random_ready");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
